seq_pattern_tx: RTL

Serial pattern transmitter: the generating end of the 10011 sequence-detector link. On a start request it shifts a fixed or programmable PAT_W-bit pattern out MSB-first, one bit per clock, repeated a programmable number of times with optional idle gaps between repetitions. It drives the serial `in` line of the sequence detector, both in-system and in loopback benches.

---
 rtl/seq_pattern_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern transmitter with repeat count, inter-repetition gaps and abort.
// Ports: clk, reset (async, active-high); start_i, use_default_i, pattern_in_i, repeat_cnt_i,
// gap_len_i (all sampled on the accepting edge); abort_i (cancels an active transfer);
// ready_o, out_o, out_valid_o, frame_start_o, done_o (all registered).
module seq_pattern_tx #(
  parameter int PAT_W = 5,
  parameter logic [PAT_W-1:0] DEF_PAT = 5'b10011,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             use_default_i,
  input  logic [PAT_W-1:0] pattern_in_i,
  input  logic [CNT_W-1:0] repeat_cnt_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             frame_start_o,
  output logic             done_o
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic ready_d, out_d, out_valid_d, frame_start_d, done_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      idx_q         <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
      gcnt_q        <= '0;
      ready_o       <= 1'b1;
      out_o         <= 1'b0;
      out_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      idx_q         <= idx_d;
      rep_q         <= rep_d;
      gap_q         <= gap_d;
      gcnt_q        <= gcnt_d;
      ready_o       <= ready_d;
      out_o         <= out_d;
      out_valid_o   <= out_valid_d;
      frame_start_o <= frame_start_d;
      done_o        <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SHIFT;
        pat_d   = use_default_i ? DEF_PAT : pattern_in_i;
        rep_d   = (repeat_cnt_i == '0) ? CNT_W'(1) : repeat_cnt_i;
        gap_d   = gap_len_i;
        idx_d   = MSB;
      end
      SHIFT: if (idx_q == '0) begin
        rep_d   = rep_q - 1'b1;
        idx_d   = MSB;
        gcnt_d  = gap_q;
        state_d = (rep_q == CNT_W'(1)) ? DONE : (gap_q != '0) ? GAP : SHIFT;
      end else begin
        idx_d = idx_q - 1'b1;
      end
      GAP: begin
        gcnt_d  = gcnt_q - 1'b1;
        state_d = (gcnt_q == GAP_W'(1)) ? SHIFT : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) state_d = IDLE;
    // Outputs are computed from the next state so the registered values line up with it.
    ready_d       = state_d == IDLE;
    out_valid_d   = state_d == SHIFT;
    out_d         = (state_d == SHIFT) & pat_d[idx_d];
    frame_start_d = (state_d == SHIFT) && (idx_d == MSB);
    done_d        = state_d == DONE;
  end
endmodule
